// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction phase sequencer: state codes,
// lamp encodings and default phase durations in ticks.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    M2_Y    = 3'd1,
    MAIN_Y  = 3'd2,
    TURN_G  = 3'd3,
    TURN_Y  = 3'd4,
    ALL_RED = 3'd5,
    SIDE_G  = 3'd6,
    SIDE_Y  = 3'd7
  } state_e;

  localparam logic [2:0] LT_GREEN = 3'b001;
  localparam logic [2:0] LT_YEL   = 3'b010;
  localparam logic [2:0] LT_RED   = 3'b100;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_T_MIN_MAIN = 7;
  localparam int DEF_T_TURN     = 5;
  localparam int DEF_T_SIDE     = 3;
  localparam int DEF_T_YEL      = 2;
  localparam int DEF_T_RED      = 1;

endpackage

// File: rtl/phase_timer.sv
// Tick counter for the current phase: clears on a phase change, can hold at
// its last value, and flags the tick on which the phase duration completes.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  input  logic             hold,
  input  logic [CNT_W-1:0] dur,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             atEnd;

  assign atEnd = (cnt_q == (dur - ONE));
  assign done  = tick && atEnd;

  // Holding only freezes the count once it has reached its final value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (tick && !(hold && atEnd))
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase sequencer for the M1/M2/MT/S junction with preemption.
// Define TRAFFIC_PED_EN to build the pedestrian request path and walk output.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int T_MIN_MAIN = DEF_T_MIN_MAIN,
  parameter int T_TURN     = DEF_T_TURN,
  parameter int T_SIDE     = DEF_T_SIDE,
  parameter int T_YEL      = DEF_T_YEL,
  parameter int T_RED      = DEF_T_RED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       req_mt,
  input  logic       req_s,
  input  logic       req_ped,
  input  logic       preempt,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] D_MIN  = CNT_W'(T_MIN_MAIN);
  localparam logic [CNT_W-1:0] D_TURN = CNT_W'(T_TURN);
  localparam logic [CNT_W-1:0] D_SIDE = CNT_W'(T_SIDE);
  localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(T_YEL);
  localparam logic [CNT_W-1:0] D_RED  = CNT_W'(T_RED);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dur;
  logic             done, clr, hold;
  logic             pendMt_q, pendMt_d, pendS_q, pendS_d;
  logic             fromSide_q, fromSide_d, emerg_q, emerg_d;
  logic             sideReq, enterTurn, enterSide, enterRed, enterMain;

  always_comb begin
    case (state_q)
      MAIN_G:  dur = D_MIN;
      TURN_G:  dur = D_TURN;
      SIDE_G:  dur = D_SIDE;
      ALL_RED: dur = D_RED;
      default: dur = D_YEL;
    endcase
  end

  assign hold = (state_q == MAIN_G) || ((state_q == ALL_RED) && preempt);
  assign clr  = (state_d != state_q);

  phase_timer #(.CNT_W(CNT_W)) uTimer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .clr  (clr),
    .hold (hold),
    .dur  (dur),
    .done (done)
  );

  assign enterTurn = (state_d == TURN_G)  && (state_q != TURN_G);
  assign enterSide = (state_d == SIDE_G)  && (state_q != SIDE_G);
  assign enterRed  = (state_d == ALL_RED) && (state_q != ALL_RED);
  assign enterMain = (state_d == MAIN_G)  && (state_q != MAIN_G);

`ifdef TRAFFIC_PED_EN
  logic pendPed_q, pendPed_d, pedServed_q, pedServed_d;

  assign sideReq     = pendS_q | pendPed_q;
  assign pendPed_d   = (pendPed_q | req_ped) & ~enterSide;
  assign pedServed_d = enterSide ? pendPed_q : (pedServed_q & (state_d == SIDE_G));
  assign walk        = (state_q == SIDE_G) && pedServed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pendPed_q   <= 1'b0;
      pedServed_q <= 1'b0;
    end else begin
      pendPed_q   <= pendPed_d;
      pedServed_q <= pedServed_d;
    end
  end
`else
  logic unused_req_ped;

  assign unused_req_ped = req_ped;
  assign sideReq        = pendS_q;
  assign walk           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= MAIN_G;
    else
      state_q <= state_d;
  end

  // Once an emergency has been seen, the clearance after it returns to main
  // rather than serving a side request left over from before the preemption.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_G: begin
        if (preempt)                state_d = MAIN_Y;
        else if (done && pendMt_q)  state_d = M2_Y;
        else if (done && sideReq)   state_d = MAIN_Y;
      end
      M2_Y:    if (done) state_d = TURN_G;
      MAIN_Y:  if (done) state_d = ALL_RED;
      TURN_G:  if (preempt || done) state_d = TURN_Y;
      TURN_Y:  if (done) state_d = ALL_RED;
      ALL_RED: begin
        if (!preempt && done)
          state_d = (sideReq && !fromSide_q && !emerg_q) ? SIDE_G : MAIN_G;
      end
      SIDE_G:  if (preempt || done) state_d = SIDE_Y;
      SIDE_Y:  if (done) state_d = ALL_RED;
      default: state_d = MAIN_G;
    endcase
  end

  assign pendMt_d   = (pendMt_q | req_mt) & ~enterTurn;
  assign pendS_d    = (pendS_q | req_s) & ~enterSide;
  assign emerg_d    = (emerg_q | preempt) & ~enterMain;
  assign fromSide_d = enterRed ? (state_q == SIDE_Y) : fromSide_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pendMt_q   <= 1'b0;
      pendS_q    <= 1'b0;
      emerg_q    <= 1'b0;
      fromSide_q <= 1'b0;
    end else begin
      pendMt_q   <= pendMt_d;
      pendS_q    <= pendS_d;
      emerg_q    <= emerg_d;
      fromSide_q <= fromSide_d;
    end
  end

  always_comb begin
    light_M1 = LT_RED;
    light_M2 = LT_RED;
    light_MT = LT_RED;
    light_S  = LT_RED;
    phase    = state_q;
    case (state_q)
      MAIN_G: begin light_M1 = LT_GREEN; light_M2 = LT_GREEN; end
      M2_Y:   begin light_M1 = LT_GREEN; light_M2 = LT_YEL;   end
      MAIN_Y: begin light_M1 = LT_YEL;   light_M2 = LT_YEL;   end
      TURN_G: begin light_M1 = LT_GREEN; light_MT = LT_GREEN; end
      TURN_Y: begin light_M1 = LT_YEL;   light_MT = LT_YEL;   end
      SIDE_G: light_S = LT_GREEN;
      SIDE_Y: light_S = LT_YEL;
      default: begin end
    endcase
  end

endmodule
